// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: access sizes, FSM states,
// byte-lane enables and store-data replication.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Lane offset after forcing natural alignment for the access size.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: align_offset = offset;
      SIZE_HALF: align_offset = {offset[1], 1'b0};
      default:   align_offset = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << offset;
      SIZE_HALF: byte_en = 4'b0011 << {offset[1], 1'b0};
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: store_data = {4{data[7:0]}};
      SIZE_HALF: store_data = {2{data[15:0]}};
      default:   store_data = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: shifts the addressed lane down to bit 0
// and sign- or zero-extends byte and half loads.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results through and runs one load/store at a time on a
// ready-handshake data bus with a timeout. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_index_i,
  input  logic [31:0] ex_alu_res_i,
  input  logic [31:0] ex_mem_data_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic        ex_mem_signed_i,
  input  logic [1:0]  ex_mem_size_i,
  output logic        stall_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  output logic [3:0]  dbe_o,
  output logic [1:0]  dsize_o,
  output logic        drd_o,
  output logic        dwr_o,
  input  logic [31:0] drdata_i,
  input  logic        dready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_index_o,
  output logic [31:0] wb_result_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_error_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t state, state_next;
  logic mem_op;
  logic take_alu, take_mem, take_trap, done_ok, done_timeout;
  logic [CNT_W-1:0] wait_cnt;

  logic        req_ld, req_st, req_signed;
  logic [1:0]  req_off, req_size;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata, load_data;

  assign mem_op = ex_mem_rd_i | ex_mem_wr_i;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (ex_mem_size_i == SIZE_HALF && ex_alu_res_i[0]) ||
                      (ex_mem_size_i == SIZE_WORD && ex_alu_res_i[1:0] != 2'b00);
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next   = state;
    take_alu     = 1'b0;
    take_mem     = 1'b0;
    take_trap    = 1'b0;
    done_ok      = 1'b0;
    done_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid_i) begin
          if (!mem_op) take_alu = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          else if (misaligned) take_trap = 1'b1;
`endif
          else begin
            take_mem   = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dready_i) begin
          done_ok    = 1'b1;
          state_next = ST_IDLE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          done_timeout = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata     (drdata_i),
    .offset    (req_off),
    .size      (req_size),
    .is_signed (req_signed),
    .data      (load_data)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_cnt      <= '0;
      req_ld        <= 1'b0;
      req_st        <= 1'b0;
      req_signed    <= 1'b0;
      req_off       <= 2'b00;
      req_size      <= 2'b00;
      req_be        <= 4'b0000;
      req_addr      <= '0;
      req_wdata     <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_index_o <= '0;
      wb_result_o   <= '0;
      mem_rdata_o   <= '0;
      mem_error_o   <= 1'b0;
    end else begin
      wb_valid_o  <= 1'b0;
      mem_error_o <= 1'b0;
      if (take_alu || take_mem || take_trap) begin
        wb_rd_index_o <= ex_rd_index_i;
        wb_result_o   <= ex_alu_res_i;
      end
      if (take_alu) begin
        wb_valid_o  <= 1'b1;
        mem_rdata_o <= '0;
      end
      if (take_trap) begin
        wb_valid_o  <= 1'b1;
        mem_error_o <= 1'b1;
        mem_rdata_o <= '0;
      end
      if (take_mem) begin
        // Both rd and wr set resolves to a store.
        req_ld     <= ex_mem_rd_i & ~ex_mem_wr_i;
        req_st     <= ex_mem_wr_i;
        req_signed <= ex_mem_signed_i;
        req_size   <= ex_mem_size_i;
        req_off    <= align_offset(ex_mem_size_i, ex_alu_res_i[1:0]);
        req_be     <= byte_en(ex_mem_size_i, ex_alu_res_i[1:0]);
        req_addr   <= {ex_alu_res_i[31:2], 2'b00};
        req_wdata  <= store_data(ex_mem_size_i, ex_mem_data_i);
        wait_cnt   <= '0;
      end
      if (state == ST_WAIT && !done_ok && !done_timeout) wait_cnt <= wait_cnt + CNT_W'(1);
      if (done_ok) begin
        wb_valid_o  <= 1'b1;
        mem_rdata_o <= req_ld ? load_data : '0;
      end
      if (done_timeout) begin
        wb_valid_o  <= 1'b1;
        mem_error_o <= 1'b1;
        mem_rdata_o <= '0;
      end
    end
  end

  assign stall_o  = (state == ST_WAIT);
  assign daddr_o  = req_addr;
  assign dwdata_o = req_wdata;
  assign dsize_o  = req_size;
  assign dbe_o    = stall_o ? req_be : 4'b0000;
  assign drd_o    = stall_o & req_ld;
  assign dwr_o    = stall_o & req_st;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; honours MEM_MISALIGN_TRAP_EN
// when selecting the expected misaligned-access behaviour.
module tb_mem_access_unit;

  logic        clk_i, reset_ni;
  logic        ex_valid_i, ex_mem_rd_i, ex_mem_wr_i, ex_mem_signed_i;
  logic [4:0]  ex_rd_index_i;
  logic [31:0] ex_alu_res_i, ex_mem_data_i;
  logic [1:0]  ex_mem_size_i;
  logic        stall_o, drd_o, dwr_o, dready_i;
  logic [31:0] daddr_o, dwdata_o, drdata_i;
  logic [3:0]  dbe_o;
  logic [1:0]  dsize_o;
  logic        wb_valid_o, mem_error_o;
  logic [4:0]  wb_rd_index_o;
  logic [31:0] wb_result_o, mem_rdata_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.MAX_WAIT(15)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .ex_valid_i(ex_valid_i), .ex_rd_index_i(ex_rd_index_i),
    .ex_alu_res_i(ex_alu_res_i), .ex_mem_data_i(ex_mem_data_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_wr_i(ex_mem_wr_i),
    .ex_mem_signed_i(ex_mem_signed_i), .ex_mem_size_i(ex_mem_size_i),
    .stall_o(stall_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dbe_o(dbe_o),
    .dsize_o(dsize_o), .drd_o(drd_o), .dwr_o(dwr_o),
    .drdata_i(drdata_i), .dready_i(dready_i),
    .wb_valid_o(wb_valid_o), .wb_rd_index_o(wb_rd_index_o),
    .wb_result_o(wb_result_o), .mem_rdata_o(mem_rdata_o), .mem_error_o(mem_error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rdi);
    ex_valid_i = 1'b1; ex_mem_rd_i = rd; ex_mem_wr_i = wr; ex_mem_signed_i = sgn;
    ex_mem_size_i = size; ex_alu_res_i = addr; ex_mem_data_i = data; ex_rd_index_i = rdi;
  endtask

  task automatic clear_op();
    ex_valid_i = 1'b0; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0; ex_mem_signed_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b1;
    clear_op();
    ex_mem_size_i = 2'b00; ex_alu_res_i = '0; ex_mem_data_i = '0; ex_rd_index_i = '0;
    dready_i = 1'b0; drdata_i = '0;
    #2 reset_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({stall_o, drd_o, dwr_o, dbe_o, dsize_o, wb_valid_o, mem_error_o} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0", {stall_o, drd_o, dwr_o, dbe_o, dsize_o, wb_valid_o, mem_error_o});
    end
    n_cmp++;
    if ({daddr_o, dwdata_o, wb_result_o, mem_rdata_o, wb_rd_index_o} !== 133'd0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h %h %h expected all 0", daddr_o, dwdata_o, wb_result_o, mem_rdata_o, wb_rd_index_o);
    end
    reset_ni = 1'b1;
  endtask

  task automatic test_alu();
    dready_i = 1'b1;
    drive_op(1'b0, 1'b0, 1'b0, 2'b10, 32'h1234_5678, 32'h0, 5'd5);
    step();
    clear_op();
    n_cmp++;
    if ({wb_valid_o, stall_o, mem_error_o} !== 3'b100) begin
      n_err++; $display("FAIL alu_valid: got %b expected 100", {wb_valid_o, stall_o, mem_error_o});
    end
    n_cmp++;
    if ({wb_result_o, mem_rdata_o, wb_rd_index_o} !== {32'h1234_5678, 32'h0, 5'd5}) begin
      n_err++; $display("FAIL alu_data: got %h %h %0d expected 12345678 0 5", wb_result_o, mem_rdata_o, wb_rd_index_o);
    end
    step();
    n_cmp++;
    if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b expected 0", wb_valid_o); end
    dready_i = 1'b0;
  endtask

  task automatic test_load_byte();
    dready_i = 1'b1; drdata_i = 32'h80FF_1234;
    drive_op(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0103, 32'h0, 5'd3);
    step();
    clear_op();
    n_cmp++;
    if ({stall_o, drd_o, dwr_o, dbe_o, wb_valid_o} !== 8'b1_1_0_1000_0) begin
      n_err++; $display("FAIL lb_req: got %b expected 11010000", {stall_o, drd_o, dwr_o, dbe_o, wb_valid_o});
    end
    n_cmp++;
    if ({daddr_o, dsize_o} !== {32'h0000_0100, 2'b00}) begin
      n_err++; $display("FAIL lb_addr: got %h %b expected 00000100 00", daddr_o, dsize_o);
    end
    step();
    n_cmp++;
    if ({wb_valid_o, mem_error_o, stall_o, drd_o, dbe_o} !== 8'b1000_0000) begin
      n_err++; $display("FAIL lb_done: got %b expected 10000000", {wb_valid_o, mem_error_o, stall_o, drd_o, dbe_o});
    end
    n_cmp++;
    if ({mem_rdata_o, wb_rd_index_o} !== {32'hFFFF_FF80, 5'd3}) begin
      n_err++; $display("FAIL lb_data: got %h %0d expected ffffff80 3", mem_rdata_o, wb_rd_index_o);
    end
    dready_i = 1'b0;
    step();
    n_cmp++;
    if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL lb_pulse: got %b expected 0", wb_valid_o); end
  endtask

  task automatic test_load_half();
    dready_i = 1'b0; drdata_i = 32'h9ABC_0000;
    drive_op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd4);
    step();
    clear_op();
    n_cmp++;
    if ({dbe_o, dsize_o, drd_o} !== 7'b1100_01_1) begin
      n_err++; $display("FAIL lhu_req: got %b expected 1100011", {dbe_o, dsize_o, drd_o});
    end
    step();
    dready_i = 1'b1;
    step();
    n_cmp++;
    if ({wb_valid_o, mem_rdata_o} !== {1'b1, 32'h0000_9ABC}) begin
      n_err++; $display("FAIL lhu_data: got %b %h expected 1 00009abc", wb_valid_o, mem_rdata_o);
    end
    drdata_i = 32'h0000_8001;
    drive_op(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0100, 32'h0, 5'd6);
    step();
    clear_op();
    step();
    n_cmp++;
    if ({wb_valid_o, mem_rdata_o} !== {1'b1, 32'hFFFF_8001}) begin
      n_err++; $display("FAIL lhs_data: got %b %h expected 1 ffff8001", wb_valid_o, mem_rdata_o);
    end
    dready_i = 1'b0;
  endtask

  task automatic test_store();
    dready_i = 1'b0; drdata_i = 32'hFFFF_FFFF;
    drive_op(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0201, 32'h0000_00A5, 5'd7);
    step();
    drive_op(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0FFF, 32'h1111_1111, 5'd9);
    n_cmp++;
    if ({daddr_o, dwdata_o, dbe_o, dwr_o, drd_o} !== {32'h0000_0200, 32'hA5A5_A5A5, 4'b0010, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sb_req: got %h %h %b %b %b expected 00000200 a5a5a5a5 0010 1 0", daddr_o, dwdata_o, dbe_o, dwr_o, drd_o);
    end
    step();
    n_cmp++;
    if ({daddr_o, dwdata_o, dbe_o, dwr_o, wb_valid_o} !== {32'h0000_0200, 32'hA5A5_A5A5, 4'b0010, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sb_hold: got %h %h %b %b %b expected 00000200 a5a5a5a5 0010 1 0", daddr_o, dwdata_o, dbe_o, dwr_o, wb_valid_o);
    end
    clear_op();
    dready_i = 1'b1;
    step();
    dready_i = 1'b0;
    n_cmp++;
    if ({wb_valid_o, mem_rdata_o, wb_rd_index_o, wb_result_o, dwr_o} !== {1'b1, 32'h0, 5'd7, 32'h0000_0201, 1'b0}) begin
      n_err++; $display("FAIL sb_done: got %b %h %0d %h %b expected 1 0 7 00000201 0", wb_valid_o, mem_rdata_o, wb_rd_index_o, wb_result_o, dwr_o);
    end
    drive_op(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0302, 32'h1234_BEEF, 5'd8);
    step();
    clear_op();
    n_cmp++;
    if ({daddr_o, dwdata_o, dbe_o, dsize_o, dwr_o, drd_o} !== {32'h0000_0300, 32'hBEEF_BEEF, 4'b1100, 2'b01, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sh_both: got %h %h %b %b %b %b expected 00000300 beefbeef 1100 01 1 0", daddr_o, dwdata_o, dbe_o, dsize_o, dwr_o, drd_o);
    end
    dready_i = 1'b1;
    step();
    dready_i = 1'b0;
    n_cmp++;
    if ({wb_valid_o, mem_rdata_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL sh_done: got %b %h expected 1 0", wb_valid_o, mem_rdata_o);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    dready_i = 1'b0; drdata_i = 32'hDEAD_BEEF;
    drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 5'd10);
    step();
    clear_op();
    cycles = 0;
    while (stall_o && cycles < 40) begin
      cycles++;
      step();
    end
    n_cmp++;
    if (cycles !== 15) begin n_err++; $display("FAIL to_stall_cycles: got %0d expected 15", cycles); end
    n_cmp++;
    if ({wb_valid_o, mem_error_o, mem_rdata_o, drd_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL to_error: got %b %b %h %b expected 1 1 0 0", wb_valid_o, mem_error_o, mem_rdata_o, drd_o);
    end
    step();
    n_cmp++;
    if ({wb_valid_o, mem_error_o, stall_o} !== 3'b000) begin
      n_err++; $display("FAIL to_pulse: got %b expected 000", {wb_valid_o, mem_error_o, stall_o});
    end
  endtask

  task automatic test_misaligned();
    dready_i = 1'b0; drdata_i = 32'h1122_3344;
    drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0102, 32'h0, 5'd11);
    step();
    clear_op();
`ifdef MEM_MISALIGN_TRAP_EN
    n_cmp++;
    if ({drd_o, stall_o, wb_valid_o, mem_error_o, mem_rdata_o} !== {4'b0011, 32'h0}) begin
      n_err++; $display("FAIL mis_trap: got %b %h expected 0011 0", {drd_o, stall_o, wb_valid_o, mem_error_o}, mem_rdata_o);
    end
    step();
    n_cmp++;
    if ({drd_o, wb_valid_o, mem_error_o} !== 3'b000) begin
      n_err++; $display("FAIL mis_after: got %b expected 000", {drd_o, wb_valid_o, mem_error_o});
    end
`else
    n_cmp++;
    if ({drd_o, dbe_o, daddr_o} !== {1'b1, 4'b1111, 32'h0000_0100}) begin
      n_err++; $display("FAIL mis_req: got %b %b %h expected 1 1111 00000100", drd_o, dbe_o, daddr_o);
    end
    dready_i = 1'b1;
    step();
    dready_i = 1'b0;
    n_cmp++;
    if ({wb_valid_o, mem_error_o, mem_rdata_o} !== {1'b1, 1'b0, 32'h1122_3344}) begin
      n_err++; $display("FAIL mis_data: got %b %b %h expected 1 0 11223344", wb_valid_o, mem_error_o, mem_rdata_o);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    dready_i = 1'b0; drdata_i = 32'h5555_AAAA;
    drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0500, 32'h0, 5'd12);
    step();
    clear_op();
    step();
    n_cmp++;
    if ({stall_o, drd_o} !== 2'b11) begin n_err++; $display("FAIL rw_pre: got %b expected 11", {stall_o, drd_o}); end
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({drd_o, stall_o, dbe_o, daddr_o} !== {6'b0, 32'h0}) begin
      n_err++; $display("FAIL rw_abort: got %b %h expected 0 0", {drd_o, stall_o, dbe_o}, daddr_o);
    end
    dready_i = 1'b1;
    step();
    n_cmp++;
    if ({wb_valid_o, mem_error_o, stall_o} !== 3'b000) begin
      n_err++; $display("FAIL rw_nopulse: got %b expected 000", {wb_valid_o, mem_error_o, stall_o});
    end
    dready_i = 1'b0;
    drive_op(1'b0, 1'b0, 1'b0, 2'b10, 32'hCAFE_F00D, 32'h0, 5'd13);
    reset_ni = 1'b1;
    step();
    clear_op();
    n_cmp++;
    if ({wb_valid_o, wb_result_o, wb_rd_index_o} !== {1'b1, 32'hCAFE_F00D, 5'd13}) begin
      n_err++; $display("FAIL rw_next: got %b %h %0d expected 1 cafef00d 13", wb_valid_o, wb_result_o, wb_rd_index_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half();
    test_store();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum cycles to wait for dready_i before the access is abandoned.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports ex_valid_i  in  1; ex_rd_index_i  in  5; ex_alu_res_i  in  32 (address or ALU result); ex_mem_data_i  in  32 (store data).
REQ-005 SHALL have ports ex_mem_rd_i, ex_mem_wr_i, ex_mem_signed_i  in  1 each; ex_mem_size_i  in  2 (byte, half or word).
REQ-006 SHALL have port stall_o  out  1  holds the execute stage.
REQ-007 SHALL have ports daddr_o  out  32; dwdata_o  out  32; dbe_o  out  4; dsize_o  out  2; drd_o, dwr_o  out  1; drdata_i  in  32; dready_i  in  1.
REQ-008 SHALL have ports wb_valid_o  out  1; wb_rd_index_o  out  5; wb_result_o  out  32 (ALU pass-through); mem_rdata_o  out  32; mem_error_o  out  1.

Function
REQ-009 SHALL implement FSM IDLE/WAIT; stall_o = (state==WAIT), decoded from registered state only.
REQ-010 IDLE, ex_valid_i=1, no memory op: SHALL register the op, giving wb_valid_o=1 next cycle with wb_result_o=ex_alu_res_i and mem_rdata_o=0.
REQ-011 IDLE, ex_valid_i=1, load or store: SHALL enter WAIT next cycle and drive a request that stays stable throughout WAIT.
REQ-012 Requests SHALL present daddr_o={addr[31:2],2'b00} and dsize_o=size; drd_o=1 for a load; dwr_o=1 for a store.
REQ-013 ex_mem_rd_i and ex_mem_wr_i both set: SHALL treat the op as a store.
REQ-014 dbe_o SHALL be 0001<<addr[1:0] for byte, 0011<<{addr[1],0} for half, and 1111 for word; dbe_o SHALL be 0000 outside WAIT.
REQ-015 dwdata_o SHALL be {4{data[7:0]}} for byte, {2{data[15:0]}} for half, and data for word.
REQ-016 drd_o, dwr_o SHALL be 0 whenever state is not WAIT.
REQ-017 WAIT with dready_i=1: load SHALL capture drdata_i>>(8*addr[1:0]); byte loads sign- or zero-extend bit 7, half loads bit 16-extend bit 15, per ex_mem_signed_i.
REQ-018 Completion SHALL assert wb_valid_o for exactly one cycle in the next cycle and return to IDLE; a store SHALL give mem_rdata_o=0.
REQ-019 SHALL give minimum memory-op latency of 2 cycles from acceptance edge to wb_valid_o; an ALU op SHALL take 1 cycle.
REQ-020 A wait counter SHALL clear on WAIT entry; if it reaches MAX_WAIT without dready_i, the request SHALL drop, wb_valid_o=1 and mem_error_o=1 for one cycle with mem_rdata_o=0, and the FSM SHALL return to IDLE.
REQ-021 dready_i SHALL be ignored outside WAIT; while stall_o=1, ex inputs SHALL be ignored.
REQ-022 wb_valid_o and mem_error_o SHALL be single-cycle pulses; wb_rd_index_o SHALL hold the accepted op's rd index.

Reset
REQ-023 reset_ni=0 SHALL immediately force IDLE and drive every output to 0, aborting any outstanding request mid-WAIT without a completion pulse.
REQ-024 The first acceptance SHALL occur on the first rising edge after reset_ni deasserts.

Configuration
REQ-025 With MEM_MISALIGN_TRAP_EN defined, half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request and stay IDLE; wb_valid_o=1 and mem_error_o=1 SHALL follow next cycle.
REQ-026 Without MEM_MISALIGN_TRAP_EN, misaligned low bits SHALL be forced aligned (half ignores addr[0], word ignores addr[1:0]) and no error SHALL be raised.

Structure
REQ-027 Package mem_pkg SHALL hold SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, the FSM state enum and the byte-enable helper function.
REQ-028 Load alignment and extension SHALL be in the combinational sub-module load_align, instantiated once.

Verification
REQ-029 Signed LB at addr 0x103, drdata_i=0x80FF_1234, dready_i the first WAIT cycle -> dbe_o=1000, mem_rdata_o=0xFFFF_FF80, wb_valid_o 2 cycles after accept.
REQ-030 Unsigned LH at 0x102, drdata_i=0x9ABC_0000 -> mem_rdata_o=0x0000_9ABC, dbe_o=1100.
REQ-031 SB at 0x201 with data 0x0000_00A5 -> daddr_o=0x200, dwdata_o=0xA5A5_A5A5, dbe_o=0010, dwr_o held until dready_i.
REQ-032 LW with dready_i held low and MAX_WAIT=15 -> stall_o high for 15 cycles, then mem_error_o=1, wb_valid_o=1, mem_rdata_o=0.
REQ-033 LW at 0x102: with MEM_MISALIGN_TRAP_EN -> drd_o never asserts and mem_error_o=1; without it -> dbe_o=1111 and daddr_o=0x100.
REQ-034 reset_ni pulled low during WAIT -> drd_o=0 in the same cycle, no wb_valid_o pulse, and next op accepted normally.
